// File: rtl/vga_pkg.sv
// Shared timing constants and enums for the 800x600@60 raster generator.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 800;
    localparam int unsigned H_FP     = 40;
    localparam int unsigned H_SYNC   = 128;
    localparam int unsigned H_BP     = 88;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_ACTIVE = 600;
    localparam int unsigned V_FP     = 1;
    localparam int unsigned V_SYNC   = 4;
    localparam int unsigned V_BP     = 23;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic HS_POL = 1'b1;
    localparam logic VS_POL = 1'b1;

    typedef enum logic {StIdle, StRun} vga_state_t;

    typedef enum logic [1:0] {PhAct, PhFp, PhSync, PhBp} vga_phase_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus its active/porch/sync phase decode.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned Active = H_ACTIVE,
    parameter int unsigned Fp     = H_FP,
    parameter int unsigned Sync   = H_SYNC,
    parameter int unsigned Bp     = H_BP,
    parameter int unsigned Width  = 11
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [Width-1:0] count_o,
    output logic             wrap_o,
    output vga_phase_t       phase_o
);

    localparam int unsigned Total = Active + Fp + Sync + Bp;
    localparam logic [Width-1:0] Last = Width'(Total - 1);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = (count_q == Last) ? '0 : count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        count_q <= count_d;
    end

    always_comb begin
        if (count_q < Width'(Active)) begin
            phase_o = PhAct;
        end else if (count_q < Width'(Active + Fp)) begin
            phase_o = PhFp;
        end else if (count_q < Width'(Active + Fp + Sync)) begin
            phase_o = PhSync;
        end else begin
            phase_o = PhBp;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = en_i && !clr_i && (count_q == Last);

endmodule

// File: rtl/vga_timing_800x600.sv
// 800x600@60 VGA timing generator gated by a synchronized PLL lock.
// Optional 8-bar colour test pattern on test_rgb_o when VGA_TEST_PATTERN_EN is defined.
module vga_timing_800x600
    import vga_pkg::*;
#(
    parameter int unsigned HActive = H_ACTIVE,
    parameter int unsigned HFp     = H_FP,
    parameter int unsigned HSync   = H_SYNC,
    parameter int unsigned HBp     = H_BP,
    parameter int unsigned VActive = V_ACTIVE,
    parameter int unsigned VFp     = V_FP,
    parameter int unsigned VSync   = V_SYNC,
    parameter int unsigned VBp     = V_BP,
    parameter logic        HsPol   = HS_POL,
    parameter logic        VsPol   = VS_POL
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pll_locked_i,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        video_on_o,
    output logic [10:0] x_o,
    output logic [9:0]  y_o,
    output logic        line_start_o,
    output logic        frame_start_o
`ifdef VGA_TEST_PATTERN_EN
    ,
    output logic [11:0] test_rgb_o
`endif
);

    logic       sync_q, lock_s_q;
    vga_state_t state_q;

    logic        run, cnt_clr, h_wrap, unused_v_wrap;
    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    vga_phase_t  h_phase, v_phase;

    logic        hsync_d, vsync_d, video_on_d, line_start_d, frame_start_d;
    logic        hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q;
    logic [10:0] x_d, x_q;
    logic [9:0]  y_d, y_q;

    assign run = (state_q == StRun);
    // Counters only move while running with lock still present; losing lock clears them.
    assign cnt_clr = rst_i || !run || !lock_s_q;

    vga_axis_counter #(
        .Active (HActive),
        .Fp     (HFp),
        .Sync   (HSync),
        .Bp     (HBp),
        .Width  (11)
    ) u_h_cnt (
        .clk_i   (clk_i),
        .en_i    (run),
        .clr_i   (cnt_clr),
        .count_o (h_cnt),
        .wrap_o  (h_wrap),
        .phase_o (h_phase)
    );

    vga_axis_counter #(
        .Active (VActive),
        .Fp     (VFp),
        .Sync   (VSync),
        .Bp     (VBp),
        .Width  (10)
    ) u_v_cnt (
        .clk_i   (clk_i),
        .en_i    (h_wrap),
        .clr_i   (cnt_clr),
        .count_o (v_cnt),
        .wrap_o  (unused_v_wrap),
        .phase_o (v_phase)
    );

    always_comb begin
        hsync_d       = ~HsPol;
        vsync_d       = ~VsPol;
        video_on_d    = 1'b0;
        x_d           = '0;
        y_d           = '0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (run) begin
            hsync_d       = (h_phase == PhSync) ? HsPol : ~HsPol;
            vsync_d       = (v_phase == PhSync) ? VsPol : ~VsPol;
            video_on_d    = (h_phase == PhAct) && (v_phase == PhAct);
            x_d           = h_cnt;
            y_d           = v_cnt;
            line_start_d  = (h_cnt == '0);
            frame_start_d = (h_cnt == '0) && (v_cnt == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q        <= 1'b0;
            lock_s_q      <= 1'b0;
            state_q       <= StIdle;
            hsync_q       <= ~HsPol;
            vsync_q       <= ~VsPol;
            video_on_q    <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            sync_q   <= pll_locked_i;
            lock_s_q <= sync_q;
            case (state_q)
                StIdle:  if (lock_s_q) state_q <= StRun;
                StRun:   if (!lock_s_q) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign video_on_o    = video_on_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0]  bar;
    logic [11:0] test_rgb_d, test_rgb_q;

    // Bar index picks R/G/B on bits 2/1/0, each channel fully on or off.
    always_comb begin
        bar        = 3'(h_cnt / 11'd100);
        test_rgb_d = video_on_d ? {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}} : 12'h000;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            test_rgb_q <= 12'h000;
        end else begin
            test_rgb_q <= test_rgb_d;
        end
    end

    assign test_rgb_o = test_rgb_q;
`endif

endmodule

// File: tb/tb_vga_timing_800x600.sv
// Bench: full-size and shrunken-geometry instances checked every cycle against a position model.
module tb_vga_timing_800x600;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        von;
        logic        ls;
        logic        fs;
        logic [10:0] x;
        logic [9:0]  y;
        logic [11:0] rgb;
    } vout_t;

    localparam int S_HA = 16, S_HF = 2, S_HS = 4, S_HB = 3;
    localparam int S_VA = 6, S_VF = 1, S_VS = 2, S_VB = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic locked = 1'b1;

    logic        f_hs, f_vs, f_von, f_ls, f_fs;
    logic [10:0] f_x;
    logic [9:0]  f_y;
    logic [11:0] f_rgb;
    logic        s_hs, s_vs, s_von, s_ls, s_fs;
    logic [10:0] s_x;
    logic [9:0]  s_y;
    logic [11:0] s_rgb;

    int  n_chk = 0;
    int  n_fail = 0;
    bit  chk_en = 1'b0;
    int  oh[4];
    vout_t exp_f, exp_s, act_f, act_s;

    always #5 clk = ~clk;

    vga_timing_800x600 dut_f (
        .clk_i         (clk),
        .rst_i         (rst),
        .pll_locked_i  (locked),
        .hsync_o       (f_hs),
        .vsync_o       (f_vs),
        .video_on_o    (f_von),
        .x_o           (f_x),
        .y_o           (f_y),
        .line_start_o  (f_ls),
        .frame_start_o (f_fs)
`ifdef VGA_TEST_PATTERN_EN
        ,
        .test_rgb_o    (f_rgb)
`endif
    );

    vga_timing_800x600 #(
        .HActive (S_HA), .HFp (S_HF), .HSync (S_HS), .HBp (S_HB),
        .VActive (S_VA), .VFp (S_VF), .VSync (S_VS), .VBp (S_VB)
    ) dut_s (
        .clk_i         (clk),
        .rst_i         (rst),
        .pll_locked_i  (locked),
        .hsync_o       (s_hs),
        .vsync_o       (s_vs),
        .video_on_o    (s_von),
        .x_o           (s_x),
        .y_o           (s_y),
        .line_start_o  (s_ls),
        .frame_start_o (s_fs)
`ifdef VGA_TEST_PATTERN_EN
        ,
        .test_rgb_o    (s_rgb)
`endif
    );

`ifndef VGA_TEST_PATTERN_EN
    assign f_rgb = 12'h000;
    assign s_rgb = 12'h000;
`endif

    assign act_f = {f_hs, f_vs, f_von, f_ls, f_fs, f_x, f_y, f_rgb};
    assign act_s = {s_hs, s_vs, s_von, s_ls, s_fs, s_x, s_y, s_rgb};

    // c = pixels emitted since the raster (re)started; 0 means outputs idle.
    function automatic vout_t model(int c, int ha, int hf, int hsw, int hb,
                                    int va, int vf, int vsw, int vb);
        vout_t o;
        int ht, vt, i, h, v, b;
        o = '0;
        if (c > 0) begin
            ht = ha + hf + hsw + hb;
            vt = va + vf + vsw + vb;
            i = c - 1;
            h = i % ht;
            v = (i / ht) % vt;
            o.x = 11'(h);
            o.y = 10'(v);
            o.hs = (h >= ha + hf) && (h < ha + hf + hsw);
            o.vs = (v >= va + vf) && (v < va + vf + vsw);
            o.von = (h < ha) && (v < va);
            o.ls = (h == 0);
            o.fs = (h == 0) && (v == 0);
            b = h / 100;
            if (o.von) begin
                o.rgb = {((b & 4) != 0) ? 4'hF : 4'h0, ((b & 2) != 0) ? 4'hF : 4'h0,
                         ((b & 1) != 0) ? 4'hF : 4'h0};
            end
`ifndef VGA_TEST_PATTERN_EN
            o.rgb = 12'h000;
`endif
        end
        return o;
    endfunction

    // oh[k] = consecutive lock-high samples ending k edges ago; output lags it by 3 edges.
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) oh[k] = 0;
        end else begin
            oh[3] = oh[2];
            oh[2] = oh[1];
            oh[1] = oh[0];
            oh[0] = locked ? oh[1] + 1 : 0;
        end
        exp_f = model(oh[3], 800, 40, 128, 88, 600, 1, 4, 23);
        exp_s = model(oh[3], S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB);
    end

    task automatic cmp(string nm, vout_t a, vout_t e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s @%0t: got hs=%0b vs=%0b von=%0b ls=%0b fs=%0b x=%0d y=%0d rgb=%h, expected hs=%0b vs=%0b von=%0b ls=%0b fs=%0b x=%0d y=%0d rgb=%h",
                     nm, $time, a.hs, a.vs, a.von, a.ls, a.fs, a.x, a.y, a.rgb,
                     e.hs, e.vs, e.von, e.ls, e.fs, e.x, e.y, e.rgb);
        end
    endtask

    task automatic chk(string nm, int a, int e);
        n_chk++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("full", act_f, exp_f);
            cmp("small", act_s, exp_s);
        end
    end

    initial begin
        int  n, cnt_v, cnt_h, first_h, last_h, last_v, max_y;
        bit  found;

        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset x", int'(f_x), 0);
        chk("reset y", int'(f_y), 0);
        chk("reset hsync", int'(f_hs), 0);
        chk("reset vsync", int'(f_vs), 0);
        chk("reset video_on", int'(f_von), 0);
        rst = 1'b0;

        // Startup latency: first frame_start on the 4th edge that sees rst low.
        n = 0;
        found = 1'b0;
        for (int i = 1; i <= 10 && !found; i++) begin
            @(negedge clk);
            if (f_fs) begin
                n = i;
                found = 1'b1;
            end
        end
        chk("first frame_start edge", n, 4);

        // One full line of the 800x600 instance.
        n = 0; cnt_v = 0; cnt_h = 0; first_h = -1; last_h = -1; last_v = -1;
        do begin
            if (f_von) begin
                cnt_v++;
                last_v = int'(f_x);
            end
            if (f_hs) begin
                cnt_h++;
                if (first_h < 0) first_h = int'(f_x);
                last_h = int'(f_x);
            end
`ifdef VGA_TEST_PATTERN_EN
            if (f_x == 11'd0)   chk("rgb x=0", int'(f_rgb), 'h000);
            if (f_x == 11'd250) chk("rgb x=250", int'(f_rgb), 'h0F0);
            if (f_x == 11'd799) chk("rgb x=799", int'(f_rgb), 'hFFF);
            if (f_x == 11'd800) chk("rgb x=800", int'(f_rgb), 'h000);
`endif
            @(negedge clk);
            n++;
        end while (!f_ls && n < 2000);
        chk("line_start period", n, 1056);
        chk("video_on clocks per line", cnt_v, 800);
        chk("hsync clocks per line", cnt_h, 128);
        chk("hsync first x", first_h, 840);
        chk("hsync last x", last_h, 967);
        chk("video_on last x", last_v, 799);

        // One full frame of the shrunken instance.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            found = s_fs;
        end
        chk("small frame_start seen", int'(found), 1);
        n = 0; cnt_v = 0; cnt_h = 0; first_h = -1; max_y = 0;
        do begin
            if (s_von) cnt_v++;
            if (s_vs) begin
                cnt_h++;
                if (first_h < 0) first_h = int'(s_y);
            end
            if (int'(s_y) > max_y) max_y = int'(s_y);
            @(negedge clk);
            n++;
        end while (!s_fs && n < 1000);
        chk("small frame period", n, 275);
        chk("small video_on per frame", cnt_v, 96);
        chk("small vsync clocks", cnt_h, 50);
        chk("small vsync first y", first_h, 7);
        chk("small max y", max_y, 10);

        // Lock loss at x=500, y=3 on the full instance.
        found = 1'b0;
        for (int i = 0; i < 6000 && !found; i++) begin
            @(negedge clk);
            found = (f_x == 11'd500) && (f_y == 10'd3);
        end
        chk("reached x=500 y=3", int'(found), 1);
        locked = 1'b0;
        repeat (3) @(negedge clk);
        chk("still active 2 edges after drop", int'(f_von), 1);
        chk("x 2 edges after drop", int'(f_x), 503);
        @(negedge clk);
        chk("video_on off 3 edges after drop", int'(f_von), 0);
        chk("x cleared 3 edges after drop", int'(f_x), 0);
        repeat (6) @(negedge clk);
        locked = 1'b1;
        n = 0;
        found = 1'b0;
        for (int i = 1; i <= 10 && !found; i++) begin
            @(negedge clk);
            if (f_fs) begin
                n = i;
                found = 1'b1;
            end
        end
        chk("relock frame_start edge", n, 4);
        chk("relock x", int'(f_x), 0);
        chk("relock y", int'(f_y), 0);

        // Random lock drops, glitches and reset pulses.
        for (int it = 0; it < 15; it++) begin
            repeat ($urandom_range(1, 2500)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst = 1'b0;
            end else begin
                locked = 1'b0;
                repeat ($urandom_range(1, 12)) @(negedge clk);
                locked = 1'b1;
            end
        end
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
